des_decrypt_core: RTL and testbench
===================================

Name: des_decrypt_core

Overview:
Iterative single-DES decryption engine that turns 64-bit ciphertext back into plaintext. It is the decrypt-side counterpart to the encrypt datapath built around s_box_48_32. The block runs one Feistel round per clock over 16 cycles and generates subkeys K16..K1 on the fly by right-rotating the key schedule. It sits between the host load interface and the plaintext output register.

Parameters:
KEY_PARITY_CHECK, 0, when 1 check odd parity on each key byte (bit 0 of each byte is the parity bit) and report the result on parity_err_o; when 0, parity_err_o is tied to 0.

Ports:
clk_i  input  1  system clock, rising edge.
rst_n_i  input  1  asynchronous active-low reset.
start_i  input  1  one-cycle request to begin decryption; sampled only in IDLE.
key_i  input  64  DES key, FIPS bit order (MSB = bit 1); sampled with start_i.
data_i  input  64  ciphertext; sampled with start_i.
busy_o  output  1  high from the cycle after start is accepted until done_o.
done_o  output  1  one-cycle pulse; data_o is valid on it.
data_o  output  64  plaintext; registered, held until the next done_o.
parity_err_o  output  1  registered with done_o; held with data_o.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; L, R, C, D and round counter cleared; busy_o=0, done_o=0, data_o=0, parity_err_o=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start_i=1 (edge T0):
  - load L||R = IP(data_i) and C||D = PC1(key_i);
  - round counter r=0; go to RUN; busy_o=1 from T0+1.
- RUN, one round per cycle, r=0..15 (edges T1..T16):
  - subkey K = PC2(C||D) from the current C/D;
  - L' = R; R' = L ^ P(S(E(R) ^ K)), where S is the 8-box 48->32 substitution;
  - C/D rotate right by RSH[r] = 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1,1. The r=0 subkey uses the unrotated PC1 output (= K16). After the final rotate, C/D are back at their PC1 value.
  - At r=15: data_o <= FP(R16||L16), i.e. swapped halves; parity_err_o updated; go to DONE.
- DONE (T17): done_o=1 for exactly one cycle, busy_o=0; return to IDLE. A start_i in DONE is ignored.
- Latency: start accepted at T0, done_o high in the cycle after edge T16, i.e. 17 cycles. Throughput is one block per 18 cycles.
- start_i while RUN or DONE is ignored; key_i and data_i may change freely after T0.
- Reset mid-operation: aborts immediately; no done_o pulse; data_o returns to 0.
- parity_err_o = 1 if any key byte has an even number of ones (KEY_PARITY_CHECK=1 only). Decryption still completes normally.
- All permutation tables follow FIPS 46-3 bit numbering (bit 1 = MSB).

Decomposition:
- des_pkg holds:
  - IP, FP, E, P, PC1 and PC2 index tables as constant arrays;
  - the RSH right-shift schedule;
  - the state enum (IDLE, RUN, DONE);
  - widths (BLOCK_W=64, HALF_W=32, SUBKEY_W=48, CD_W=28).
- One sub-module, des_f_function (combinational): R[31:0], K[47:0] -> f[31:0]. It does the E expansion, the key XOR, instantiates s_box_48_32, then applies P. The same module is shared with the encrypt core.
- Key schedule rotation and the FSM stay in the top module.

Test Plan:
- FIPS vector: key 133457799BBCDFF1, data_i 85E813540F0AB405 -> done_o after 17 cycles; data_o=0123456789ABCDEF; parity_err_o=0.
- Vector 2: key 0E329232EA6D0D73, data_i 0000000000000000 -> data_o=8787878787878787; busy_o high for exactly 16 cycles.
- Back-to-back: start on vector 1, pulse start_i again at cycles 5 and 17 (ignored), then start vector 2 in IDLE. Required: exactly two done_o pulses with correct data, and data_o holds vector 1's result until vector 2's done.
- Parity (KEY_PARITY_CHECK=1): key 0000000000000000, any data -> done_o at 17 cycles with parity_err_o=1. Vector 1 key -> parity_err_o=0.
- Reset mid-run: assert rst_n_i at round 8 for 1 cycle -> outputs 0 immediately, no done_o. A fresh start with vector 1 then yields 0123456789ABCDEF.
- Subkey check: probe PC2(C||D) on round 0 for key 133457799BBCDFF1 -> K16 = CB3D8B0E17F5. On round 15 -> K1 = 1B02EFFC7072.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: widths, FSM states and the FIPS 46-3 permutation tables.
// The table entries use FIPS numbering, where bit 1 is the MSB of the vector.
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int HALF_W   = 32;
    localparam int SUBKEY_W = 48;
    localparam int CD_W     = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32, 1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1
    };

    localparam int P_T [32] = '{
        16, 7,  20, 21, 29, 12, 28, 17,  1,  15, 23, 26, 5,  18, 31, 10,
        2,  8,  24, 14, 32, 27, 3,  9,   19, 13, 30, 6,  22, 11, 4,  25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,   1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27,  19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29,  21, 13, 5,  28, 20, 12, 4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,   3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,   16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    // Right-rotate amounts that walk C/D back from K16 to K1 during decryption.
    localparam int RSH [16] = '{1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1, 1};

    function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int i = 0; i < BLOCK_W; i++) y[BLOCK_W-1-i] = x[BLOCK_W-IP_T[i]];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] fp_perm(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int i = 0; i < BLOCK_W; i++) y[BLOCK_W-1-i] = x[BLOCK_W-FP_T[i]];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] e_perm(input logic [HALF_W-1:0] x);
        logic [SUBKEY_W-1:0] y;
        for (int i = 0; i < SUBKEY_W; i++) y[SUBKEY_W-1-i] = x[HALF_W-E_T[i]];
        return y;
    endfunction

    function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] x);
        logic [HALF_W-1:0] y;
        for (int i = 0; i < HALF_W; i++) y[HALF_W-1-i] = x[HALF_W-P_T[i]];
        return y;
    endfunction

    function automatic logic [2*CD_W-1:0] pc1_perm(input logic [BLOCK_W-1:0] x);
        logic [2*CD_W-1:0] y;
        for (int i = 0; i < 2*CD_W; i++) y[2*CD_W-1-i] = x[BLOCK_W-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2_perm(input logic [2*CD_W-1:0] x);
        logic [SUBKEY_W-1:0] y;
        for (int i = 0; i < SUBKEY_W; i++) y[SUBKEY_W-1-i] = x[2*CD_W-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] x, input int amount);
        return (amount == 1) ? {x[0], x[CD_W-1:1]} : {x[1:0], x[CD_W-1:2]};
    endfunction

    // A DES key byte is well-formed when it holds an odd number of ones.
    function automatic logic key_parity_bad(input logic [BLOCK_W-1:0] key);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) bad |= ~^key[8*i+7 -: 8];
        return bad;
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K) = P(S(E(R) ^ K)); purely combinational.
// Used by both the encrypt and decrypt cores.
module des_f_function
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r_i,
    input  logic [SUBKEY_W-1:0] k_i,
    output logic [HALF_W-1:0]   f_o
);

    logic [SUBKEY_W-1:0] mixed;
    logic [HALF_W-1:0]   sbox_out;

    assign mixed = e_perm(r_i) ^ k_i;

    s_box_48_32 u_s_box (
        .x_i (mixed),
        .y_o (sbox_out)
    );

    assign f_o = p_perm(sbox_out);

endmodule

// File: rtl/s_box_48_32.sv
// The eight DES substitution boxes: each 6-bit group selects a 4-bit value.
// The outer bits pick the row and the inner four bits pick the column.
module s_box_48_32 (
    input  logic [47:0] x_i,
    output logic [31:0] y_o
);

    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    always_comb begin
        y_o = '0;
        for (int j = 0; j < 8; j++) begin
            logic [5:0] b;
            b = x_i[47-6*j -: 6];
            y_o[31-4*j -: 4] = 4'(SBOX[j][{b[5], b[0], b[4:1]}]);
        end
    end

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative single-DES decryption: one Feistel round per clock over 16 cycles,
// with subkeys K16..K1 produced by right-rotating C/D in place.
module des_decrypt_core
    import des_pkg::*;
#(
    parameter bit KEY_PARITY_CHECK = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [BLOCK_W-1:0] key_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               parity_err_o
);

    state_e              state_q, state_d;
    logic [3:0]          round_q, round_d;
    logic [HALF_W-1:0]   l_q, l_d, r_q, r_d;
    logic [CD_W-1:0]     c_q, c_d, d_q, d_d;
    logic [BLOCK_W-1:0]  data_q, data_d;
    logic                par_pend_q, par_pend_d;
    logic                parity_q, parity_d;

    logic [SUBKEY_W-1:0] subkey;
    logic [HALF_W-1:0]   f_out;

    // The first RUN cycle sees the unrotated PC1 value, which is K16.
    assign subkey = pc2_perm({c_q, d_q});

    des_f_function u_f (
        .r_i (r_q),
        .k_i (subkey),
        .f_o (f_out)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        round_d    = round_q;
        l_d        = l_q;
        r_d        = r_q;
        c_d        = c_q;
        d_d        = d_q;
        data_d     = data_q;
        par_pend_d = par_pend_q;
        parity_d   = parity_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = RUN;
                    round_d    = '0;
                    {l_d, r_d} = ip_perm(data_i);
                    {c_d, d_d} = pc1_perm(key_i);
                    // PC1 drops the parity bits, so capture the verdict now.
                    par_pend_d = KEY_PARITY_CHECK && key_parity_bad(key_i);
                end
            end
            RUN: begin
                l_d     = r_q;
                r_d     = l_q ^ f_out;
                c_d     = rotr(c_q, RSH[round_q]);
                d_d     = rotr(d_q, RSH[round_q]);
                round_d = round_q + 4'd1;
                if (round_q == 4'd15) begin
                    state_d  = DONE;
                    data_d   = fp_perm({r_d, l_d});
                    parity_d = par_pend_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            round_q    <= '0;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            data_q     <= '0;
            par_pend_q <= 1'b0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            l_q        <= l_d;
            r_q        <= r_d;
            c_q        <= c_d;
            d_q        <= d_d;
            data_q     <= data_d;
            par_pend_q <= par_pend_d;
            parity_q   <= parity_d;
        end
    end

    assign busy_o       = (state_q == RUN);
    assign done_o       = (state_q == DONE);
    assign data_o       = data_q;
    assign parity_err_o = parity_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known-answer vectors, latency, parity,
// ignored starts, mid-run reset and subkey probes.
module tb_des_decrypt_core;

    localparam logic [63:0] V1_KEY = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] V1_CT  = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] V1_PT  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] V2_KEY = 64'h0E32_9232_EA6D_0D73;
    localparam logic [63:0] V2_CT  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] V2_PT  = 64'h8787_8787_8787_8787;
    localparam logic [47:0] K16    = 48'hCB3D_8B0E_17F5;
    localparam logic [47:0] K1     = 48'h1B02_EFFC_7072;

    logic        clk_i;
    logic        rst_n_i;
    logic        start_i;
    logic [63:0] key_i;
    logic [63:0] data_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] data_o;
    logic        parity_err_o;

    int assertions = 0;
    int failures   = 0;

    des_decrypt_core #(.KEY_PARITY_CHECK(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .key_i        (key_i),
        .data_i       (data_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .data_o       (data_o),
        .parity_err_o (parity_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Start a block and wait for done; lat counts cycles from the start cycle
    // (0 means done never came). Inputs are scrambled after acceptance.
    task automatic run_block(input logic [63:0] key, input logic [63:0] ct,
                             output logic [63:0] pt, output int lat,
                             output int busy_cnt, output logic perr);
        @(negedge clk_i);
        key_i = key; data_i = ct; start_i = 1'b1;
        lat = 0; busy_cnt = 0; pt = '0; perr = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            key_i = ~key; data_i = ~ct;
            if (busy_o) busy_cnt++;
            if (done_o) begin
                lat = c; pt = data_o; perr = parity_err_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; start_i = 1'b0; key_i = V1_KEY; data_i = V1_CT;
        repeat (3) @(negedge clk_i);
        assertions++;
        if ({busy_o, done_o, parity_err_o, data_o} !== 67'd0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b perr=%b data=%h, want all 0",
                     busy_o, done_o, parity_err_o, data_o);
            failures++;
        end
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        assertions++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy_o, done_o);
            failures++;
        end
    endtask

    task automatic test_fips_vector();
        logic [63:0] pt; int lat, bc; logic perr;
        run_block(V1_KEY, V1_CT, pt, lat, bc, perr);
        assertions++;
        if (lat !== 17) begin
            $display("FAIL v1_latency: got %0d cycles, want 17", lat); failures++;
        end
        assertions++;
        if (pt !== V1_PT) begin
            $display("FAIL v1_data: got %h, want %h", pt, V1_PT); failures++;
        end
        assertions++;
        if (perr !== 1'b0) begin
            $display("FAIL v1_parity: got %b, want 0", perr); failures++;
        end
        @(negedge clk_i);
        assertions++;
        if (done_o !== 1'b0 || data_o !== V1_PT) begin
            $display("FAIL v1_done_pulse_hold: got done=%b data=%h, want done=0 data=%h",
                     done_o, data_o, V1_PT);
            failures++;
        end
    endtask

    task automatic test_vector2();
        logic [63:0] pt; int lat, bc; logic perr;
        run_block(V2_KEY, V2_CT, pt, lat, bc, perr);
        assertions++;
        if (pt !== V2_PT) begin
            $display("FAIL v2_data: got %h, want %h", pt, V2_PT); failures++;
        end
        assertions++;
        if (bc !== 16) begin
            $display("FAIL v2_busy_cycles: got %0d, want 16", bc); failures++;
        end
        assertions++;
        if (lat !== 17) begin
            $display("FAIL v2_latency: got %0d cycles, want 17", lat); failures++;
        end
    endtask

    task automatic test_subkeys();
        @(negedge clk_i);
        key_i = V1_KEY; data_i = V1_CT; start_i = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (c == 1) begin
                assertions++;
                if (dut.subkey !== K16) begin
                    $display("FAIL subkey_round0: got %h, want %h", dut.subkey, K16); failures++;
                end
            end
            if (c == 16) begin
                assertions++;
                if (dut.subkey !== K1) begin
                    $display("FAIL subkey_round15: got %h, want %h", dut.subkey, K1); failures++;
                end
            end
        end
        assertions++;
        if (done_o !== 1'b1 || data_o !== V1_PT) begin
            $display("FAIL subkey_run_result: got done=%b data=%h, want 1 %h", done_o, data_o, V1_PT);
            failures++;
        end
    endtask

    task automatic test_parity();
        logic [63:0] pt; int lat, bc; logic perr;
        run_block(64'h0, 64'h0123_4567_89AB_CDEF, pt, lat, bc, perr);
        assertions++;
        if (lat !== 17) begin
            $display("FAIL parity_latency: got %0d cycles, want 17", lat); failures++;
        end
        assertions++;
        if (perr !== 1'b1) begin
            $display("FAIL parity_zero_key: got %b, want 1", perr); failures++;
        end
        repeat (2) @(negedge clk_i);
        assertions++;
        if (parity_err_o !== 1'b1) begin
            $display("FAIL parity_held: got %b, want 1", parity_err_o); failures++;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] pt; int lat, bc; logic perr; int stray;
        @(negedge clk_i);
        key_i = V1_KEY; data_i = V1_CT; start_i = 1'b1;
        repeat (9) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        assertions++;
        if (dut.round_q !== 4'd8) begin
            $display("FAIL mid_run_round: got %0d, want 8", dut.round_q); failures++;
        end
        rst_n_i = 1'b0;
        #1;
        assertions++;
        if ({busy_o, done_o, parity_err_o, data_o} !== 67'd0) begin
            $display("FAIL mid_run_reset_outputs: got busy=%b done=%b perr=%b data=%h, want all 0",
                     busy_o, done_o, parity_err_o, data_o);
            failures++;
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        stray = 0;
        repeat (25) begin
            @(negedge clk_i);
            if (done_o || busy_o) stray++;
        end
        assertions++;
        if (stray !== 0) begin
            $display("FAIL mid_run_no_done: got %0d busy/done cycles, want 0", stray); failures++;
        end
        run_block(V1_KEY, V1_CT, pt, lat, bc, perr);
        assertions++;
        if (pt !== V1_PT || lat !== 17) begin
            $display("FAIL after_reset_v1: got data=%h lat=%0d, want %h 17", pt, lat, V1_PT);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0; int first_done = 0; int second_done = 0; int hold_bad = 0;
        @(negedge clk_i);
        key_i = V1_KEY; data_i = V1_CT; start_i = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_o) begin
                dones++;
                if (dones == 1) begin
                    first_done = c;
                    assertions++;
                    if (data_o !== V1_PT) begin
                        $display("FAIL b2b_first_data: got %h, want %h", data_o, V1_PT); failures++;
                    end
                end else begin
                    second_done = c;
                    assertions++;
                    if (data_o !== V2_PT) begin
                        $display("FAIL b2b_second_data: got %h, want %h", data_o, V2_PT); failures++;
                    end
                end
            end else if (c > 17 && c < 37 && data_o !== V1_PT) begin
                hold_bad++;
            end
            if (c == 18) begin
                assertions++;
                if (busy_o !== 1'b0) begin
                    $display("FAIL b2b_start_in_done: got busy=%b, want 0", busy_o); failures++;
                end
            end
            if (c == 5 || c == 17) begin
                key_i = 64'h0; data_i = 64'hFFFF_FFFF_FFFF_FFFF; start_i = 1'b1;
            end
            if (c == 20) begin
                key_i = V2_KEY; data_i = V2_CT; start_i = 1'b1;
            end
        end
        assertions++;
        if (dones !== 2) begin
            $display("FAIL b2b_done_count: got %0d, want 2", dones); failures++;
        end
        assertions++;
        if (first_done !== 17 || second_done !== 37) begin
            $display("FAIL b2b_done_cycles: got %0d and %0d, want 17 and 37", first_done, second_done);
            failures++;
        end
        assertions++;
        if (hold_bad !== 0) begin
            $display("FAIL b2b_hold: got %0d cycles without V1 result, want 0", hold_bad); failures++;
        end
    endtask

    initial begin
        test_reset();
        test_fips_vector();
        test_vector2();
        test_subkeys();
        test_parity();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
